serial_frame_controller: RTL

Receive-side controller for the serial link. It hunts for the 4-bit preamble 1101 on `serIn`, then captures a 2-bit destination port and a 4-bit payload length. It then steers exactly that many payload bits to one of four output channels and pulses `done`. It sits between the raw serial input and the per-channel consumers, and sequences the capture, count and steer datapath that a plain detector plus external counter would otherwise need.

---
 rtl/serial_frame_controller.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_frame_controller.sv
// ---------------------------------------------------------------------------
// serial_frame_controller: preamble hunt, header capture, payload steering
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module serial_frame_controller #(
  parameter int NPORTS = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clkEn,
  input  logic              serIn,
  output logic              serOut,
  output logic [NPORTS-1:0] chValid,
  output logic [1:0]        portAddr,
  output logic              busy,
  output logic              done
);

  localparam int CNT_W = (LEN_W > 2) ? $clog2(LEN_W) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_P1, S_P11, S_P110, S_ADDR, S_LEN, S_DATA, S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [1:0]         portAddr_q, portAddr_d;
  logic [LEN_W-1:0]   lenReg_q, lenReg_d;
  logic [LEN_W-1:0]   remCnt_q, remCnt_d;
  logic [CNT_W-1:0]   fldCnt_q, fldCnt_d;
  logic [LEN_W-1:0]   w_lenNext;

  assign w_lenNext = (lenReg_q << 1) | LEN_W'(serIn);

  always_comb begin
    state_d    = state_q;
    portAddr_d = portAddr_q;
    lenReg_d   = lenReg_q;
    remCnt_d   = remCnt_q;
    fldCnt_d   = fldCnt_q;
    if (clkEn) begin
      case (state_q)
        S_IDLE: state_d = serIn ? S_P1   : S_IDLE;
        S_P1:   state_d = serIn ? S_P11  : S_IDLE;
        S_P11:  state_d = serIn ? S_P11  : S_P110;
        S_P110: state_d = serIn ? S_ADDR : S_IDLE;
        S_ADDR: begin
          portAddr_d = (portAddr_q << 1) | 2'(serIn);
          if (fldCnt_q == CNT_W'(1)) begin
            fldCnt_d = '0;
            state_d  = S_LEN;
          end else begin
            fldCnt_d = fldCnt_q + CNT_W'(1);
          end
        end
        S_LEN: begin
          lenReg_d = w_lenNext;
          if (fldCnt_q == CNT_W'(LEN_W - 1)) begin
            fldCnt_d = '0;
            // A zero-length frame skips DATA entirely.
            if (w_lenNext == '0) begin
              state_d = S_DONE;
            end else begin
              remCnt_d = w_lenNext;
              state_d  = S_DATA;
            end
          end else begin
            fldCnt_d = fldCnt_q + CNT_W'(1);
          end
        end
        S_DATA: begin
          remCnt_d = remCnt_q - LEN_W'(1);
          if (remCnt_q == LEN_W'(1)) state_d = S_DONE;
        end
        S_DONE:  state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      portAddr_q <= '0;
      lenReg_q   <= '0;
      remCnt_q   <= '0;
      fldCnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      portAddr_q <= portAddr_d;
      lenReg_q   <= lenReg_d;
      remCnt_q   <= remCnt_d;
      fldCnt_q   <= fldCnt_d;
    end
  end

  assign serOut   = (state_q == S_DATA) & serIn;
  assign chValid  = (state_q == S_DATA) ? (NPORTS'(1) << portAddr_q) : '0;
  assign portAddr = portAddr_q;
  assign busy     = (state_q == S_ADDR) || (state_q == S_LEN) ||
                    (state_q == S_DATA) || (state_q == S_DONE);
  assign done     = (state_q == S_DONE);

endmodule

`default_nettype wire
